// File: rtl/sample3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample3_pkg : shared defaults and word type for the sample3 block     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sample3_pkg;

  localparam int SAMPLE3_WIDTH = 32;
  localparam int SAMPLE3_DEPTH = 4;
  localparam int SAMPLE3_DROPW = 8;

  typedef logic [SAMPLE3_WIDTH-1:0] sample3_word_t;

endpackage
`default_nettype wire

// File: rtl/sample3_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample3_fifo : registered-output FIFO with occupancy count           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sample3_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     valid_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      level_d  = level_d + (AW+1)'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d  = level_d - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push_i && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign valid_o = (level_q != '0);

endmodule
`default_nettype wire

// File: rtl/sample3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample3 : buffers a valid-only stream into a valid/ready FIFO, counts |
// | drops and returns an accepted-word count. Option: SAMPLE3_ACCUM_EN    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sample3
  import sample3_pkg::*;
#(
  parameter int WIDTH = SAMPLE3_WIDTH,
  parameter int DEPTH = SAMPLE3_DEPTH,
  parameter int DROPW = SAMPLE3_DROPW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     to3_dValid,
  input  logic [WIDTH-1:0]         to3_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROPW-1:0]         drop_cnt,
  output logic [WIDTH-1:0]         to2_b
);

  localparam int               LW         = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);

  logic             pop;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] head;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0] to2_b_q, to2_b_d;

  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = to3_dValid && ((level < FULL_LEVEL) || pop);
  assign drop = to3_dValid && !push;

  sample3_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (to3_d),
    .rdata_o (head),
    .level_o (level),
    .valid_o (out_valid)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    to2_b_d    = to2_b_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROPW'(1);
    end
    if (push) begin
      to2_b_d = to2_b_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      to2_b_q    <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      to2_b_q    <= to2_b_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign to2_b    = to2_b_q;

`ifdef SAMPLE3_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  // Presented value is the accumulator as it will be after this pop.
  assign out_data = acc_q + head;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (pop) begin
      acc_q <= out_data;
    end
  end
`else
  assign out_data = head;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sample3 : randomized scoreboard bench for sample3                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sample3;
  import sample3_pkg::*;

  localparam int WIDTH = SAMPLE3_WIDTH;
  localparam int DEPTH = SAMPLE3_DEPTH;
  localparam int DROPW = SAMPLE3_DROPW;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROPW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             to3_dValid = 1'b0;
  logic [WIDTH-1:0] to3_d = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic [DROPW-1:0] drop_cnt;
  logic [WIDTH-1:0] to2_b;

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy, counters and the ordered list of expected words.
  sample3_word_t    exp_q[$];
  int               m_level = 0;
  int               m_drop  = 0;
  logic [WIDTH-1:0] m_to2b  = '0;
  logic [WIDTH-1:0] run_sum = '0;

  sample3 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DROPW (DROPW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .to3_dValid (to3_dValid),
    .to3_d      (to3_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .to2_b      (to2_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock: check state left by the previous edge, then issue new inputs.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                      input logic rst = 1'b0);
    logic p_pop;
    logic p_push;
    @(posedge clk);
    #1;
    chk("level", 64'(level), 64'(m_level));
    chk("out_valid", 64'(out_valid), 64'(m_level != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("to2_b", 64'(to2_b), 64'(m_to2b));
    reset      = rst;
    to3_dValid = v;
    to3_d      = d;
    out_ready  = rdy;
    if (rst) begin
      m_level = 0;
      m_drop  = 0;
      m_to2b  = '0;
      run_sum = '0;
      exp_q.delete();
    end else begin
      p_pop  = (m_level > 0) && rdy;
      p_push = v && ((m_level < DEPTH) || p_pop);
      if (p_push) begin
        m_to2b  = m_to2b + 1;
        run_sum = run_sum + d;
`ifdef SAMPLE3_ACCUM_EN
        exp_q.push_back(run_sum);
`else
        exp_q.push_back(d);
`endif
      end else if (v && m_drop < DROP_MAX) begin
        m_drop = m_drop + 1;
      end
      m_level = m_level + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
    end
  endtask

  // Monitor: whenever a head is presented, it must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("head_data", 64'(out_data), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);

    // In-order delivery with a held head
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h30, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0);

    // Overflow drops the newest words
    for (int i = 1; i <= 6; i++) step(1'b1, WIDTH'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    repeat (DEPTH + 1) step(1'b0, '0, 1'b1);

    // Push into a full FIFO during a pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'hA0 + i), 1'b0);
    step(1'b1, 32'h55, 1'b1);
    step(1'b0, '0, 1'b0);
    repeat (DEPTH + 1) step(1'b0, '0, 1'b1);

    // Drop counter saturation
    for (int i = 0; i < DEPTH + 260; i++) step(1'b1, WIDTH'(i), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    repeat (DEPTH + 1) step(1'b0, '0, 1'b1);

    // Reset while occupied
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(32'hC0 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0);

    // Accumulator wrap pattern (plain passthrough in the default build)
    step(1'b1, 32'd5, 1'b0);
    step(1'b1, 32'd7, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, '0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
    end

    repeat (DEPTH + 2) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample3.md
Name: sample3

Overview:
- Downstream consumer of sample2's to3_d stream. That stream is valid-only, with no backpressure.
- Accepts each valid word into a small FIFO and drains it to a standard valid/ready consumer.
- Counts words dropped on overflow.
- Returns an accepted-word counter to sample2's to2_b input, closing the sample loop.

Parameters:
- WIDTH, 32, data width of to3_d / out_data / to2_b.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- DROPW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- to3_dValid  input  1  upstream word valid; no ready exists.
- to3_d  input  WIDTH  upstream word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  WIDTH  FIFO head (or accumulated value; see Optional Feature).
- level  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  DROPW  words dropped, saturating.
- to2_b  output  WIDTH  accepted-word counter fed back to sample2.

Behaviour:
- Reset, sampled on posedge clk: level=0, out_valid=0, drop_cnt=0, to2_b=0, rd_ptr=wr_ptr=0. Storage contents are not reset; out_data is don't-care while out_valid=0.
- Reset asserted mid-operation discards all entries next edge; no pop or push occurs in a reset cycle.
- pop = out_valid && out_ready.
- push = to3_dValid && (level<DEPTH || pop). A push into a full FIFO is allowed in the same cycle as a pop.
- drop = to3_dValid && !push. On drop, drop_cnt increments by 1, saturating at 2^DROPW-1, never wrapping. The dropped word is lost.
- level' = level + push - pop. Simultaneous push+pop leaves level unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- out_valid = (level!=0), driven from registers with no combinational path from to3_dValid.
- out_data = mem[rd_ptr].
- Latency: a word pushed at edge N is presented at out_valid/out_data after edge N, i.e. 1 cycle. There is no empty bypass.
- out_data is held stable while out_valid && !out_ready.
- to2_b' = to2_b + 1 on each push, wrapping mod 2^WIDTH. It is registered, so sample2 sees the new value 1 cycle after acceptance.
- out_ready with empty FIFO: no effect.

Optional Feature:
- Macro SAMPLE3_ACCUM_EN.
- When defined:
  - An internal WIDTH-bit register acc (reset 0) holds the running sum of popped entries.
  - out_data = acc + mem[rd_ptr], truncated to WIDTH bits, i.e. the value acc takes after this pop.
  - On pop, acc <= out_data.
  - out_data must remain stable while stalled.
- When undefined: out_data = mem[rd_ptr] and no acc register exists.
- Ports are identical in both builds.

Decomposition:
- Package sample3_pkg holds:
  - localparam defaults SAMPLE3_WIDTH=32, SAMPLE3_DEPTH=4, SAMPLE3_DROPW=8.
  - typedef logic [SAMPLE3_WIDTH-1:0] sample3_word_t.
- One sub-module, sample3_fifo: storage, pointers, level, push/pop. It is parameterised by WIDTH/DEPTH.
- sample3 top contains the drop counter, the to2_b counter and the optional accumulator.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, level=0, drop_cnt=0, to2_b=0.
- Push 0x10, 0x20, 0x30 on consecutive cycles with out_ready=0 -> level=3, to2_b=3, out_data=0x10 held. Then out_ready=1 for 3 cycles -> data 0x10, 0x20, 0x30 in order, then out_valid=0.
- out_ready=0, push 6 words 1..6 with DEPTH=4 -> level=4, drop_cnt=2, to2_b=4. Drain yields 1,2,3,4.
- Fill to 4 entries, then push 0x55 while out_ready=1 in the same cycle -> no drop, level stays 4, 0x55 is the last word drained.
- Force drop_cnt to 255 via 260 overflow pushes -> drop_cnt stays 255.
- Assert reset with level=3 -> next cycle level=0, out_valid=0, to2_b=0.
- With SAMPLE3_ACCUM_EN, pushes 5, 7, 0xFFFFFFFF -> out_data sequence 5, 12, 11 (wrap).
